serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; sampled on the cycle start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled on the cycle start is accepted.
REQ-007 c_in  input  1  initial carry; sampled on the cycle start is accepted.
REQ-008 busy  output  1  high while an addition is in progress, in SHIFT and DONE.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 c_out  output  1  registered final carry.
REQ-012 overflow  output  1  registered signed overflow flag (see Configuration).

Function
REQ-013 The block SHALL sequence one full-adder cell (sum = a^b^c, carry = ab | c(a^b)) bit-serially, LSB first, one bit per clock.
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 IDLE + start=1 -> load a, b into shift registers, carry flop <= c_in, bit counter <= 0, go to SHIFT.
REQ-016 Each SHIFT cycle -> add the LSBs of the operand registers with the carry flop; shift the result bit into the MSB of the result register; shift the operands right by one; carry flop <= new carry; counter += 1.
REQ-017 SHIFT with counter == WIDTH-1 -> after that bit is processed, go to DONE.
REQ-018 DONE -> done=1 for exactly one cycle, sum/c_out/overflow valid; go to IDLE on the next edge unconditionally.
REQ-019 Latency: start accepted at edge N -> done high during cycle N+WIDTH+1, i.e. WIDTH SHIFT cycles followed by one DONE cycle.
REQ-020 start SHALL be ignored in SHIFT and DONE; an operand change while busy SHALL have no effect.
REQ-021 sum, c_out and overflow SHALL hold their values from DONE until the next accepted start, and SHALL be updated only when entering DONE.
REQ-022 The result SHALL equal (a + b + c_in) mod 2^WIDTH, with c_out equal to bit WIDTH of the full sum.
REQ-023 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap inside one operation.
REQ-024 start held high continuously SHALL launch back-to-back operations, one every WIDTH+2 cycles.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0, carry flop=0, counter=0.
REQ-026 Reset during SHIFT or DONE SHALL abort the operation; no done pulse is produced for it.
REQ-027 The first start is accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro SERIAL_ADD_OVF_EN defined: overflow SHALL be the carry into the MSB XOR the carry out of the MSB, captured on entry to DONE.
REQ-029 Macro SERIAL_ADD_OVF_EN undefined: the overflow port SHALL remain present and tied to 0, and the MSB carry-in tracking logic SHALL be omitted.

Verification (WIDTH=8, SERIAL_ADD_OVF_EN defined unless noted)
REQ-030 a=0x5A, b=0x3C, c_in=0, start -> done at cycle +9, sum=0x96, c_out=0, overflow=1.
REQ-031 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0; a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1.
REQ-032 a=0x80, b=0x80, c_in=0 -> sum=0x00, c_out=1, overflow=1; same stimulus with the macro undefined -> overflow=0.
REQ-033 Pulse start with a=0x01, b=0x01 during cycles 3 and 9 of an active operation -> first result unchanged, only one done pulse, busy stays high through DONE.
REQ-034 Assert reset at SHIFT cycle 4 -> all outputs 0 and IDLE immediately, no done pulse; a fresh start of 0x10+0x20 -> sum=0x30.
REQ-035 start held high for 3 operations -> done pulses spaced exactly 10 cycles apart, each with correct results.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB first, one bit per clock.
// Define SERIAL_ADD_OVF_EN to enable the signed overflow flag; otherwise overflow is tied to 0.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             carryOut_q, carryOut_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic bitA, bitB, sumBit, carryNew, lastBit;

  assign bitA     = opA_q[0];
  assign bitB     = opB_q[0];
  assign sumBit   = bitA ^ bitB ^ carry_q;
  assign carryNew = (bitA & bitB) | (carry_q & (bitA ^ bitB));
  assign lastBit  = (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // The counter holds on the final bit rather than wrapping back to zero.
  always_comb begin
    opA_d      = opA_q;
    opB_d      = opB_q;
    res_d      = res_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    carryOut_d = carryOut_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opA_d   = a;
          opB_d   = b;
          carry_d = c_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        res_d   = {sumBit, res_q[WIDTH-1:1]};
        opA_d   = opA_q >> 1;
        opB_d   = opB_q >> 1;
        carry_d = carryNew;
        if (lastBit) begin
          sum_d      = {sumBit, res_q[WIDTH-1:1]};
          carryOut_d = carryNew;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opA_q      <= '0;
      opB_q      <= '0;
      res_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      carryOut_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      res_q      <= res_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      carryOut_q <= carryOut_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == SHIFT && lastBit) ovf_d = carry_q ^ carryNew;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign sum   = sum_q;
  assign c_out = carryOut_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table, random ops vs arithmetic model,
// and hand-written sequences for ignored start, mid-operation reset and back-to-back starts.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] aIn;
  logic [WIDTH-1:0] bIn;
  logic             cIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cOut;
  logic             overflow;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (aIn),
    .b        (bIn),
    .c_in     (cIn),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (cOut),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer addition, signed overflow from operand/result signs.
  function automatic logic [9:0] modelAdd(input logic [7:0] opA, input logic [7:0] opB,
                                          input logic cinV);
    logic [8:0] full;
    logic       ovf;
    full = {1'b0, opA} + {1'b0, opB} + {8'b0, cinV};
    ovf  = OVF_EN && (opA[7] == opB[7]) && (full[7] != opA[7]);
    return {ovf, full};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete operation from an idle DUT; operands are scrambled while busy.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input logic cinV,
                               input logic [7:0] eSum, input logic eCout, input logic eOvf,
                               input string tag);
    int edges;
    @(negedge clk);
    start = 1'b1; aIn = opA; bIn = opB; cIn = cinV;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; aIn = 8'($urandom); bIn = 8'($urandom); cIn = 1'($urandom);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done && edges < 40);
    checkOutput({tag, "_latency"}, 32'(edges), 32'(WIDTH));
    checkOutput({tag, "_sum"}, 32'(sum), 32'(eSum));
    checkOutput({tag, "_cout"}, 32'(cOut), 32'(eCout));
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(eOvf));
    checkOutput({tag, "_busyDone"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_hold"}, 32'(sum), 32'(eSum));
  endtask

  initial begin
    logic [9:0] m;
    logic [7:0] ra, rb;
    logic       rc;
    int         doneCount, doneEdge, idx, lastDone;
    logic [7:0] bbA[3];
    logic [7:0] bbB[3];
    logic       bbC[3];

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    reset = 1'b0; start = 1'b0; aIn = '0; bIn = '0; cIn = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cOut), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                    vecs[i].ovf & OVF_EN, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      m = modelAdd(ra, rb, rc);
      applyStimulus(ra, rb, rc, m[7:0], m[8], m[9], $sformatf("rnd%0d", i));
    end

    // start pulses while busy (one in SHIFT, one in DONE) must be ignored
    @(negedge clk);
    start = 1'b1; aIn = 8'h5A; bIn = 8'h3C; cIn = 1'b0;
    @(posedge clk);
    doneCount = 0; doneEdge = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 9); aIn = 8'h01; bIn = 8'h01; cIn = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        doneCount++;
        if (doneCount == 1) begin
          doneEdge = k;
          checkOutput("ign_sum", 32'(sum), 32'h96);
          checkOutput("ign_cout", 32'(cOut), 32'd0);
          checkOutput("ign_ovf", 32'(overflow), 32'(OVF_EN));
          checkOutput("ign_busy", 32'(busy), 32'd1);
        end
      end
    end
    start = 1'b0;
    checkOutput("ign_doneCount", 32'(doneCount), 32'd1);
    checkOutput("ign_doneEdge", 32'(doneEdge), 32'd8);
    checkOutput("ign_idle", 32'(busy), 32'd0);
    checkOutput("ign_sumHold", 32'(sum), 32'h96);

    // asynchronous reset during SHIFT aborts the operation
    @(negedge clk);
    start = 1'b1; aIn = 8'hC3; bIn = 8'h5A; cIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_cout", 32'(cOut), 32'd0);
    checkOutput("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doneCount = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) doneCount++;
    end
    checkOutput("abort_noDone", 32'(doneCount), 32'd0);
    applyStimulus(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "afterAbort");

    // start held high: three back-to-back operations
    bbA[0] = 8'h12; bbB[0] = 8'h34; bbC[0] = 1'b0;
    bbA[1] = 8'hF0; bbB[1] = 8'h20; bbC[1] = 1'b1;
    bbA[2] = 8'h7F; bbB[2] = 8'h7F; bbC[2] = 1'b0;
    @(negedge clk);
    start = 1'b1; aIn = bbA[0]; bIn = bbB[0]; cIn = bbC[0];
    idx = 0; lastDone = 0;
    for (int k = 1; k <= 60 && idx < 3; k++) begin
      @(posedge clk); #1;
      if (done) begin
        m = modelAdd(bbA[idx], bbB[idx], bbC[idx]);
        checkOutput($sformatf("b2b%0d_sum", idx), 32'(sum), 32'(m[7:0]));
        checkOutput($sformatf("b2b%0d_cout", idx), 32'(cOut), 32'(m[8]));
        checkOutput($sformatf("b2b%0d_ovf", idx), 32'(overflow), 32'(m[9]));
        if (idx > 0) checkOutput($sformatf("b2b%0d_spacing", idx), 32'(k - lastDone), 32'd10);
        lastDone = k;
        idx++;
        @(negedge clk);
        if (idx < 3) begin
          aIn = bbA[idx]; bIn = bbB[idx]; cIn = bbC[idx];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b_count", 32'(idx), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
